// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester RAM arbiter.
package ram_arb_pkg;

    localparam int unsigned N_REQ = 2;

    typedef logic arb_id_t;

    // m1 is treated as the previous owner out of reset so m0 wins the first tie
    localparam arb_id_t RST_OWNER = 1'b1;

    function automatic arb_id_t other_id(input arb_id_t id);
        return arb_id_t'(~id);
    endfunction

endpackage

// File: rtl/rr_burst_sel.sv
// Round-robin requester select with a bounded burst length under contention.
module rr_burst_sel
    import ram_arb_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4
)
(
    input  logic             clk,
    input  logic             rst_i,
    input  logic [N_REQ-1:0] i_req,
    output logic [N_REQ-1:0] o_gnt_c,
    output arb_id_t          o_sel_id_c,
    output logic             o_sel_vld_c
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    arb_id_t          r_last_owner;
    arb_id_t          w_last_owner_nxt;
    arb_id_t          w_sel_id;
    logic [CNT_W-1:0] r_burst_cnt;
    logic [CNT_W-1:0] w_burst_cnt_nxt;
    logic             w_sel_vld;
    logic             w_keep_owner;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_last_owner <= RST_OWNER;
            r_burst_cnt  <= '0;
        end else begin
            r_last_owner <= w_last_owner_nxt;
            r_burst_cnt  <= w_burst_cnt_nxt;
        end
    end

    // Pick a requester, then advance the burst tracking for that choice
    always_comb begin
        w_sel_vld        = 1'b0;
        w_sel_id         = 1'b0;
        w_last_owner_nxt = r_last_owner;
        w_burst_cnt_nxt  = '0;
        w_keep_owner     = (r_burst_cnt != '0) && (r_burst_cnt < CNT_MAX);

        case (i_req)
            2'b01: begin
                w_sel_vld = 1'b1;
                w_sel_id  = 1'b0;
            end
            2'b10: begin
                w_sel_vld = 1'b1;
                w_sel_id  = 1'b1;
            end
            2'b11: begin
                w_sel_vld = 1'b1;
                w_sel_id  = w_keep_owner ? r_last_owner : other_id(r_last_owner);
            end
            default: begin
                w_sel_vld = 1'b0;
            end
        endcase

        if (w_sel_vld) begin
            if ((w_sel_id == r_last_owner) && (r_burst_cnt != '0)) begin
                w_burst_cnt_nxt = (r_burst_cnt == CNT_MAX) ? CNT_MAX : r_burst_cnt + CNT_ONE;
            end else begin
                w_burst_cnt_nxt  = CNT_ONE;
                w_last_owner_nxt = w_sel_id;
            end
        end
    end

    // The one-hot grant is suppressed while reset is asserted
    always_comb begin
        o_gnt_c = '0;
        if (w_sel_vld && !rst_i) begin
            o_gnt_c[w_sel_id] = 1'b1;
        end
        o_sel_id_c  = w_sel_id;
        o_sel_vld_c = w_sel_vld;
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between instruction fetch (m0) and load/store (m1).
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH) + 1,
    parameter int unsigned MAX_BURST  = 4
)
(
    input  logic                          clk,
    input  logic                          rst_i,
    input  logic [N_REQ-1:0]              m_req_i,
    input  logic [N_REQ-1:0]              m_we_i,
    input  logic [N_REQ*ADDR_WIDTH-1:0]   m_addr_i,
    input  logic [N_REQ*WORD_WIDTH-1:0]   m_wdata_i,
    output logic [N_REQ-1:0]              m_gnt_o,
    output logic [N_REQ-1:0]              m_rvalid_o,
    output logic [WORD_WIDTH-1:0]         m_rdata_o,
    output logic                          ram_en_o,
    output logic                          ram_we_o,
    output logic [ADDR_WIDTH-1:0]         ram_addr_o,
    output logic [WORD_WIDTH-1:0]         ram_din_o,
    input  logic [WORD_WIDTH-1:0]         ram_dout_i
);

    logic [ADDR_WIDTH-1:0] w_addr  [N_REQ];
    logic [WORD_WIDTH-1:0] w_wdata [N_REQ];
    logic [N_REQ-1:0]      w_gnt;
    logic [N_REQ-1:0]      w_rd_gnt;
    arb_id_t               w_sel_id;
    logic                  w_sel_vld;
    logic [N_REQ-1:0]      r_rvalid;
    logic [WORD_WIDTH-1:0] r_rdata;

    rr_burst_sel #(
        .MAX_BURST (MAX_BURST)
    ) u_sel (
        .clk         (clk),
        .rst_i       (rst_i),
        .i_req       (m_req_i),
        .o_gnt_c     (w_gnt),
        .o_sel_id_c  (w_sel_id),
        .o_sel_vld_c (w_sel_vld)
    );

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            w_addr[i]  = m_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            w_wdata[i] = m_wdata_i[i*WORD_WIDTH +: WORD_WIDTH];
        end
    end

    // Selected requester drives the RAM port; enable is the only gated strobe in reset
    always_comb begin
        ram_en_o   = |w_gnt;
        ram_we_o   = 1'b0;
        ram_addr_o = '0;
        ram_din_o  = '0;
        if (w_sel_vld) begin
            ram_we_o   = m_we_i[w_sel_id];
            ram_addr_o = w_addr[w_sel_id];
            ram_din_o  = w_wdata[w_sel_id];
        end
    end

    assign w_rd_gnt = w_gnt & ~m_we_i;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_rvalid <= '0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= w_rd_gnt;
            if (|w_rd_gnt) begin
                r_rdata <= ram_dout_i;
            end
        end
    end

    assign m_gnt_o    = w_gnt;
    assign m_rvalid_o = r_rvalid;
    assign m_rdata_o  = r_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scenario bench for ram_arbiter with a behavioural RAM and grant/readback model.
module tb_ram_arbiter;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned WW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned MB    = 4;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [1:0]    req;
    logic [1:0]    we;
    logic [AW-1:0] addr  [2];
    logic [WW-1:0] wdata [2];
    logic [2*AW-1:0] m_addr;
    logic [2*WW-1:0] m_wdata;

    logic [1:0]    m_gnt_o;
    logic [1:0]    m_rvalid_o;
    logic [WW-1:0] m_rdata_o;
    logic          ram_en_o;
    logic          ram_we_o;
    logic [AW-1:0] ram_addr_o;
    logic [WW-1:0] ram_din_o;
    logic [WW-1:0] ram_dout;

    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [WW-1:0] pre_data;
    logic [WW-1:0] ram_mem [2**AW];

    logic [WW-1:0] mem_ref [2**AW];
    int            mdl_last;
    int            mdl_run;
    logic [1:0]    mdl_prev_g;
    logic [1:0]    exp_rvalid;
    logic [WW-1:0] exp_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign m_addr  = {addr[1], addr[0]};
    assign m_wdata = {wdata[1], wdata[0]};

    always @(posedge clk) begin
        if (pre_we) ram_mem[pre_addr] <= pre_data;
        else if (ram_en_o && ram_we_o) ram_mem[ram_addr_o] <= ram_din_o;
    end
    assign ram_dout = ram_mem[ram_addr_o];

    ram_arbiter #(
        .DEPTH      (DEPTH),
        .WORD_WIDTH (WW),
        .ADDR_WIDTH (AW),
        .MAX_BURST  (MB)
    ) dut (
        .clk        (clk),
        .rst_i      (rst_i),
        .m_req_i    (req),
        .m_we_i     (we),
        .m_addr_i   (m_addr),
        .m_wdata_i  (m_wdata),
        .m_gnt_o    (m_gnt_o),
        .m_rvalid_o (m_rvalid_o),
        .m_rdata_o  (m_rdata_o),
        .ram_en_o   (ram_en_o),
        .ram_we_o   (ram_we_o),
        .ram_addr_o (ram_addr_o),
        .ram_din_o  (ram_din_o),
        .ram_dout_i (ram_dout)
    );

    // Owner keeps the port while its unbroken run under contention is shorter than MB
    function automatic logic [1:0] mdl_gnt();
        int owner;
        if (rst_i || req == 2'b00) return 2'b00;
        if (req == 2'b01) return 2'b01;
        if (req == 2'b10) return 2'b10;
        if (mdl_run >= 1 && mdl_run < MB) owner = mdl_last;
        else owner = 1 - mdl_last;
        return (owner == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic tick();
        logic [1:0] g;
        int idx;
        @(posedge clk);
        g = mdl_gnt();
        if (rst_i) begin
            mdl_last   = 1;
            mdl_run    = 0;
            exp_rvalid = 2'b00;
            exp_rdata  = '0;
            mdl_prev_g = 2'b00;
        end else begin
            exp_rvalid = 2'b00;
            if (g != 2'b00) begin
                idx = g[1] ? 1 : 0;
                if (we[idx]) begin
                    mem_ref[addr[idx]] = wdata[idx];
                end else begin
                    exp_rvalid = g;
                    exp_rdata  = mem_ref[addr[idx]];
                end
                if (idx == mdl_last && mdl_run >= 1) begin
                    mdl_run++;
                end else begin
                    mdl_run  = 1;
                    mdl_last = idx;
                end
            end else begin
                mdl_run = 0;
            end
            mdl_prev_g = g;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        req   = 2'b00;
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        req   = 2'b11;
        we    = 2'b00;
        @(negedge clk);
        checks++; if (m_gnt_o !== 2'b00) begin failures++; $display("FAIL rst_gnt: got %b expected 00", m_gnt_o); end
        checks++; if (ram_en_o !== 1'b0) begin failures++; $display("FAIL rst_ram_en: got %b expected 0", ram_en_o); end
        tick();
        rst_i = 1'b0;
        req   = 2'b00;
        @(negedge clk);
        checks++; if (m_rvalid_o !== 2'b00) begin failures++; $display("FAIL rst_rvalid: got %b expected 00", m_rvalid_o); end
        checks++; if (m_rdata_o !== 32'h0) begin failures++; $display("FAIL rst_rdata: got %h expected 0", m_rdata_o); end
        checks++; if (m_gnt_o !== 2'b00) begin failures++; $display("FAIL idle_gnt: got %b expected 00", m_gnt_o); end
        tick();
    endtask

    task automatic test_single_read();
        req = 2'b01; we = 2'b01; addr[0] = 5'd3; wdata[0] = 32'hDEADBEEF;
        @(negedge clk);
        checks++; if (m_gnt_o !== 2'b01) begin failures++; $display("FAIL wr_gnt: got %b expected 01", m_gnt_o); end
        checks++; if (ram_we_o !== 1'b1 || ram_addr_o !== 5'd3 || ram_din_o !== 32'hDEADBEEF) begin
            failures++; $display("FAIL wr_drive: got we=%b addr=%0d din=%h expected we=1 addr=3 din=deadbeef", ram_we_o, ram_addr_o, ram_din_o);
        end
        tick();
        we = 2'b00;
        @(negedge clk);
        checks++; if (m_gnt_o !== 2'b01 || ram_we_o !== 1'b0) begin failures++; $display("FAIL rd_gnt: got gnt=%b we=%b expected gnt=01 we=0", m_gnt_o, ram_we_o); end
        checks++; if (m_rvalid_o !== 2'b00) begin failures++; $display("FAIL wr_no_rvalid: got %b expected 00", m_rvalid_o); end
        tick();
        req = 2'b00;
        @(negedge clk);
        checks++; if (m_rvalid_o !== 2'b01) begin failures++; $display("FAIL rd_rvalid: got %b expected 01", m_rvalid_o); end
        checks++; if (m_rdata_o !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_rdata: got %h expected deadbeef", m_rdata_o); end
        tick();
    endtask

    task automatic test_first_tie();
        do_reset();
        req = 2'b11; we = 2'b00; addr[0] = 5'd1; addr[1] = 5'd2;
        @(negedge clk);
        checks++; if (m_gnt_o !== 2'b01) begin failures++; $display("FAIL first_tie: got %b expected 01", m_gnt_o); end
        tick();
        req = 2'b00;
        @(negedge clk);
        checks++; if (m_rvalid_o !== 2'b01 || m_rdata_o !== exp_rdata) begin
            failures++; $display("FAIL first_tie_rd: got %b/%h expected 01/%h", m_rvalid_o, m_rdata_o, exp_rdata);
        end
        tick();
    endtask

    task automatic test_burst_limit();
        logic [1:0] pat;
        do_reset();
        req = 2'b11; we = 2'b00;
        addr[0] = 5'($urandom_range(0, DEPTH-1));
        addr[1] = 5'($urandom_range(0, DEPTH-1));
        for (int c = 0; c < 12; c++) begin
            pat = ((c / 4) % 2 == 1) ? 2'b10 : 2'b01;
            @(negedge clk);
            checks++; if (m_gnt_o !== pat) begin failures++; $display("FAIL burst_gnt[%0d]: got %b expected %b", c, m_gnt_o, pat); end
            checks++; if (m_rvalid_o !== exp_rvalid || m_rdata_o !== exp_rdata) begin
                failures++; $display("FAIL burst_rd[%0d]: got %b/%h expected %b/%h", c, m_rvalid_o, m_rdata_o, exp_rvalid, exp_rdata);
            end
            tick();
            for (int i = 0; i < 2; i++) if (mdl_prev_g[i]) addr[i] = 5'($urandom_range(0, DEPTH-1));
        end
        req = 2'b00;
        @(negedge clk);
        checks++; if (m_rvalid_o !== 2'b01 || m_rdata_o !== exp_rdata) begin
            failures++; $display("FAIL burst_last_rd: got %b/%h expected 01/%h", m_rvalid_o, m_rdata_o, exp_rdata);
        end
        tick();
    endtask

    task automatic test_idle_resets_burst();
        do_reset();
        req = 2'b10; we = 2'b00; addr[1] = 5'd4; addr[0] = 5'd5;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++; if (m_gnt_o !== 2'b10) begin failures++; $display("FAIL idle_m1_gnt[%0d]: got %b expected 10", c, m_gnt_o); end
            tick();
        end
        req = 2'b00;
        @(negedge clk);
        checks++; if (m_gnt_o !== 2'b00 || ram_en_o !== 1'b0) begin failures++; $display("FAIL idle_gap: got gnt=%b en=%b expected 00/0", m_gnt_o, ram_en_o); end
        tick();
        req = 2'b11;
        @(negedge clk);
        checks++; if (m_gnt_o !== 2'b01) begin failures++; $display("FAIL idle_tie: got %b expected 01", m_gnt_o); end
        tick();
        req = 2'b00;
        tick();
    endtask

    task automatic test_stream();
        req = 2'b10; we = 2'b00;
        for (int c = 0; c < 8; c++) begin
            addr[1] = 5'(c);
            @(negedge clk);
            checks++; if (m_gnt_o !== 2'b10 || ram_addr_o !== 5'(c)) begin
                failures++; $display("FAIL stream_gnt[%0d]: got %b addr=%0d expected 10 addr=%0d", c, m_gnt_o, ram_addr_o, c);
            end
            checks++; if (m_rvalid_o !== exp_rvalid || m_rdata_o !== exp_rdata) begin
                failures++; $display("FAIL stream_rd[%0d]: got %b/%h expected %b/%h", c, m_rvalid_o, m_rdata_o, exp_rvalid, exp_rdata);
            end
            tick();
        end
        req = 2'b00;
        @(negedge clk);
        checks++; if (m_rvalid_o !== 2'b10 || m_rdata_o !== mem_ref[7]) begin
            failures++; $display("FAIL stream_last: got %b/%h expected 10/%h", m_rvalid_o, m_rdata_o, mem_ref[7]);
        end
        tick();
    endtask

    task automatic test_reset_mid_read();
        req = 2'b01; we = 2'b00; addr[0] = 5'd3;
        @(negedge clk);
        checks++; if (m_gnt_o !== 2'b01) begin failures++; $display("FAIL mid_pre_gnt: got %b expected 01", m_gnt_o); end
        tick();
        rst_i = 1'b1; addr[0] = 5'd5;
        @(negedge clk);
        checks++; if (m_gnt_o !== 2'b00 || ram_en_o !== 1'b0) begin failures++; $display("FAIL mid_rst_gnt: got gnt=%b en=%b expected 00/0", m_gnt_o, ram_en_o); end
        checks++; if (m_rvalid_o !== 2'b01 || m_rdata_o !== 32'hDEADBEEF) begin
            failures++; $display("FAIL mid_pre_rd: got %b/%h expected 01/deadbeef", m_rvalid_o, m_rdata_o);
        end
        tick();
        rst_i = 1'b0; req = 2'b00;
        @(negedge clk);
        checks++; if (m_rvalid_o !== 2'b00) begin failures++; $display("FAIL mid_rvalid: got %b expected 00", m_rvalid_o); end
        checks++; if (m_rdata_o !== 32'h0) begin failures++; $display("FAIL mid_rdata: got %h expected 0", m_rdata_o); end
        tick();
        req = 2'b11;
        @(negedge clk);
        checks++; if (m_gnt_o !== 2'b01) begin failures++; $display("FAIL mid_tie: got %b expected 01", m_gnt_o); end
        tick();
        req = 2'b00;
        tick();
    endtask

    task automatic test_random();
        logic [1:0] eg;
        int idx;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!(req[i] && !mdl_prev_g[i] && $urandom_range(0, 9) != 0)) begin
                    req[i]   = ($urandom_range(0, 2) != 0);
                    we[i]    = ($urandom_range(0, 2) == 0);
                    addr[i]  = 5'($urandom_range(0, DEPTH-1));
                    wdata[i] = $urandom;
                end
            end
            rst_i = ($urandom_range(0, 99) == 0);
            @(negedge clk);
            eg = mdl_gnt();
            checks++; if (m_gnt_o !== eg || ram_en_o !== (eg != 2'b00)) begin
                failures++; $display("FAIL rnd_gnt[%0d]: got %b en=%b expected %b", c, m_gnt_o, ram_en_o, eg);
            end
            checks++; if (m_rvalid_o !== exp_rvalid || m_rdata_o !== exp_rdata) begin
                failures++; $display("FAIL rnd_rd[%0d]: got %b/%h expected %b/%h", c, m_rvalid_o, m_rdata_o, exp_rvalid, exp_rdata);
            end
            if (eg != 2'b00) begin
                idx = eg[1] ? 1 : 0;
                checks++; if (ram_we_o !== we[idx] || ram_addr_o !== addr[idx] || ram_din_o !== wdata[idx]) begin
                    failures++; $display("FAIL rnd_drive[%0d]: got we=%b addr=%0d din=%h expected we=%b addr=%0d din=%h",
                                         c, ram_we_o, ram_addr_o, ram_din_o, we[idx], addr[idx], wdata[idx]);
                end
            end
            tick();
        end
        rst_i = 1'b0;
        req   = 2'b00;
        tick();
    endtask

    initial begin
        rst_i = 1'b1; req = 2'b00; we = 2'b00;
        addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        mdl_last = 1; mdl_run = 0; mdl_prev_g = 2'b00;
        exp_rvalid = 2'b00; exp_rdata = '0;
        for (int i = 0; i < 2**AW; i++) begin
            pre_we     = 1'b1;
            pre_addr   = AW'(i);
            pre_data   = $urandom;
            mem_ref[i] = pre_data;
            tick();
        end
        pre_we = 1'b0;

        test_reset();
        test_single_read();
        test_first_tie();
        test_burst_limit();
        test_idle_resets_burst();
        test_stream();
        test_reset_mid_read();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
